mdu_seq: RTL and testbench

//  Iterative multiply/divide unit. It is the multi-cycle counterpart to the

---
 rtl/mdu_seq.sv | 164 ++++++++++++++++
 tb/tb_mdu_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_seq
//  Purpose  : Iterative radix-2 multiply/divide unit with internal HI/LO
//             registers, start/busy/done handshake and direct HI/LO writes.
//  Revision : 1.0 - initial release
// ============================================================================
module mdu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  // Multiply: {upper partial product, remaining multiplier bits}
  // Divide  : {partial remainder, dividend bits shifting into quotient}
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operand;   // |multiplicand| or |divisor|
  logic               is_div;
  logic               dz_pend;
  logic               neg_res;
  logic               neg_rem;

  // Operand decode and magnitude extraction at request time
  logic               op_signed;
  logic               op_div;
  logic               b_zero;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;

  assign op_signed = ~op[0];
  assign op_div    = op[1];
  assign b_zero    = (src_b == '0);
  assign abs_a     = (op_signed && src_a[WIDTH-1]) ? (~src_a + 1'b1) : src_a;
  assign abs_b     = (op_signed && src_b[WIDTH-1]) ? (~src_b + 1'b1) : src_b;

  // One iteration of each algorithm
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;

  assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
  assign mul_next  = {mul_sum, acc[WIDTH-1:1]};
  // Shifted remainder is below 2*divisor, so WIDTH+1 bits hold the signed trial
  assign div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, operand};
  assign div_next  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  // Sign fix-up of the magnitude results
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign prod_fix = neg_res ? (~acc + 1'b1) : acc;
  assign quo_fix  = neg_res ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
  assign rem_fix  = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];

  assign busy = (state != S_IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic; divide by zero skips the iteration phase
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (start) next_state = (op_div && b_zero) ? S_FIX : S_CALC;
      S_CALC: if (cnt == LAST_STEP) next_state = S_FIX;
      S_FIX:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, result write-back, direct writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      operand  <= '0;
      is_div   <= 1'b0;
      dz_pend  <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt     <= '0;
            is_div  <= op_div;
            dz_pend <= op_div & b_zero;
            neg_res <= op_signed & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            neg_rem <= op_signed & op_div & src_a[WIDTH-1];
            if (op_div) begin
              operand <= abs_b;
              // Raw dividend is kept for the divide-by-zero result
              acc     <= {{WIDTH{1'b0}}, b_zero ? src_a : abs_a};
            end else begin
              operand <= abs_a;
              acc     <= {{WIDTH{1'b0}}, abs_b};
            end
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        S_CALC: begin
          cnt <= cnt + CNT_W'(1);
          acc <= is_div ? div_next : mul_next;
        end
        S_FIX: begin
          done     <= 1'b1;
          div_zero <= dz_pend;
          if (dz_pend) begin
            hi <= acc[WIDTH-1:0];
            lo <= {WIDTH{1'b1}};
          end else if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mdu_seq
//  Purpose  : Directed, table-driven self-checking bench for mdu_seq.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_seq;

  localparam int W = 32;
  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int tests = 0;
  int fails = 0;

  mdu_seq #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    logic         exp_dz;
    int           exp_lat;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for its done pulse
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] r_hi, output logic [W-1:0] r_lo,
                        output logic r_dz, output int lat, output int busy_cnt,
                        output logic done_after);
    @(negedge clk);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    lat = -1;
    r_hi = '0; r_lo = '0; r_dz = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c; r_hi = hi; r_lo = lo; r_dz = div_zero;
        break;
      end
      if (busy) busy_cnt++;
    end
    @(posedge clk); #1;
    done_after = done;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] r_hi, r_lo;
    logic         r_dz, d_after;
    int           lat, bcnt;

    vecs[0]  = '{OP_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33};
    vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33};
    vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33};
    vecs[3]  = '{OP_DIVU,  32'd7,         32'd2,        32'd1,         32'd3,         1'b0, 33};
    vecs[4]  = '{OP_DIVU,  32'h1234,      32'd0,        32'h1234,      32'hFFFF_FFFF, 1'b1, 1};
    vecs[5]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 1'b0, 33};
    vecs[6]  = '{OP_MULT,  32'd6,         32'd7,        32'd0,         32'd42,        1'b0, 33};
    vecs[7]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 1'b0, 33};
    vecs[8]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        1'b0, 33};
    vecs[9]  = '{OP_DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1};
    vecs[10] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd1,        32'd0,         32'hFFFF_FFFF, 1'b0, 33};
    vecs[11] = '{OP_MULTU, 32'h1234_5678, 32'h10,       32'd1,         32'h2345_6780, 1'b0, 33};
    vecs[12] = '{OP_DIV,   32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd2,        1'b0, 33};
    vecs[13] = '{OP_DIVU,  32'hFFFF_FFF9, 32'd2,        32'd1,         32'h7FFF_FFFC, 1'b0, 33};

    // Reset state
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_div_zero", {63'd0, div_zero}, 64'd0);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven operations
    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r_hi, r_lo, r_dz, lat, bcnt, d_after);
      check($sformatf("v%0d_hi", i), {32'd0, r_hi}, {32'd0, vecs[i].exp_hi});
      check($sformatf("v%0d_lo", i), {32'd0, r_lo}, {32'd0, vecs[i].exp_lo});
      check($sformatf("v%0d_div_zero", i), {63'd0, r_dz}, {63'd0, vecs[i].exp_dz});
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      check($sformatf("v%0d_busy_cycles", i), 64'(bcnt), 64'(vecs[i].exp_lat));
      check($sformatf("v%0d_done_pulse_width", i), {63'd0, d_after}, 64'd0);
    end

    // Start and hi_we during busy are ignored
    @(negedge clk);
    op = OP_DIVU; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    op = OP_MULTU; src_a = 32'd3; src_b = 32'd5; start = 1'b1;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (done) begin lat = c; break; end
    end
    check("busy_ignore_latency", 64'(lat), 64'd27);
    check("busy_ignore_hi", {32'd0, hi}, 64'd2);
    check("busy_ignore_lo", {32'd0, lo}, 64'd14);
    check("busy_ignore_div_zero", {63'd0, div_zero}, 64'd0);

    // Direct writes in IDLE, both at once
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthi_hi", {32'd0, hi}, {32'd0, 32'hA5A5_A5A5});
    check("mtlo_lo", {32'd0, lo}, {32'd0, 32'hA5A5_A5A5});
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h1357_9BDF;
    @(posedge clk); #1;
    hi_we = 1'b0;
    check("mthi_only_hi", {32'd0, hi}, {32'd0, 32'h1357_9BDF});
    check("mthi_only_lo", {32'd0, lo}, {32'd0, 32'hA5A5_A5A5});

    // hi_we together with start in IDLE is ignored
    @(negedge clk);
    op = OP_MULT; src_a = 32'd2; src_b = 32'd3; start = 1'b1;
    hi_we = 1'b1; wdata = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0;
    check("we_with_start_hi", {32'd0, hi}, {32'd0, 32'h1357_9BDF});
    check("we_with_start_busy", {63'd0, busy}, 64'd1);

    // Back-to-back: new start in the done cycle
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (done) begin lat = c; break; end
    end
    check("b2b_first_lo", {32'd0, lo}, 64'd6);
    @(negedge clk);
    op = OP_DIVU; src_a = 32'd50; src_b = 32'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_accept_busy", {63'd0, busy}, 64'd1);
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (done) begin lat = c; break; end
    end
    check("b2b_latency", 64'(lat), 64'd33);
    check("b2b_hi", {32'd0, hi}, 64'd2);
    check("b2b_lo", {32'd0, lo}, 64'd6);

    // Asynchronous abort mid-MULT
    @(negedge clk);
    op = OP_MULT; src_a = 32'd123; src_b = 32'd456; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_hi", {32'd0, hi}, 64'd0);
    check("abort_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done || busy) lat++;
    end
    check("abort_no_done", 64'(lat), 64'd0);
    run_op(OP_MULT, 32'd6, 32'd7, r_hi, r_lo, r_dz, lat, bcnt, d_after);
    check("after_abort_hi", {32'd0, r_hi}, 64'd0);
    check("after_abort_lo", {32'd0, r_lo}, 64'd42);
    check("after_abort_latency", 64'(lat), 64'd33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
